// File: rtl/tagged_multicaster.sv
// tagged_multicaster: per-PE multicast endpoint between a column bus and one PE.
// There are three tagged channels (ifmap, fltr, psum). Each channel has its own FIFO.
// A fire pulse goes to the PE, and its result returns over a valid/ready handshake.
// Optional feature macro: TMC_BROADCAST_EN. It adds the bus_bcast input, which makes
// a beat match regardless of its tag.
//
// Handshake rules, on both the bus side and the result side:
//   A transfer happens at a rising clk edge where valid and ready are both high.
//   Once res_valid is raised, res_valid and res_data hold until res_ready accepts them.
//   bus_ready is derived from the beat's own tag, the channel mask and the registered
//   full flags only. It never looks at a same-cycle pop.

`default_nettype none

// Channel FIFO. Each pointer carries one extra wrap bit, so full and empty can be
// told apart without a separate counter.
module tmc_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;

    assign o_full  = ((r_wr ^ r_rd) == PW'(DEPTH));
    assign o_empty = (r_wr == r_rd);
    assign o_dout  = r_mem[r_rd[AW-1:0]];

    // Pointer update; callers only push when not full and only pop when not empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + PW'(1);
            if (i_pop)  r_rd <= r_rd + PW'(1);
        end
    end

    // Storage write; contents need no reset because empty pointers gate every read.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr[AW-1:0]] <= i_din;
    end
endmodule

module tagged_multicaster #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int FIFO_DEPTH = 2,
    localparam int IDW       = $clog2(NUM_COL)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    id_wr,
    input  logic [IDW-1:0]          id_in,
    input  logic [2:0]              cfg_ch_mask,
    input  logic [2:0]              bus_valid,
    output logic [2:0]              bus_ready,
    input  logic [3*IDW-1:0]        bus_tag,
`ifdef TMC_BROADCAST_EN
    input  logic [2:0]              bus_bcast,
`endif
    input  logic [DATA_WIDTH-1:0]   bus_ifmap,
    input  logic [DATA_WIDTH-1:0]   bus_fltr,
    input  logic [2*DATA_WIDTH-1:0] bus_psum,
    input  logic                    pe_ready,
    output logic                    pe_en,
    output logic [DATA_WIDTH-1:0]   pe_ifmap,
    output logic [DATA_WIDTH-1:0]   pe_fltr,
    output logic [2*DATA_WIDTH-1:0] pe_psum,
    input  logic                    pe_valid,
    input  logic [2*DATA_WIDTH-1:0] pe_res,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_WIDTH-1:0] res_data,
    output logic                    err
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [IDW-1:0]          r_id;
    logic [2:0]              w_match;
    logic [2:0]              w_push;
    logic [2:0]              w_pop;
    logic [2:0]              w_full;
    logic [2:0]              w_empty;
    logic                    w_fire;
    logic [DATA_WIDTH-1:0]   w_head_ifmap;
    logic [DATA_WIDTH-1:0]   w_head_fltr;
    logic [2*DATA_WIDTH-1:0] w_head_psum;

    logic                    r_pe_en;
    logic [DATA_WIDTH-1:0]   r_pe_ifmap;
    logic [DATA_WIDTH-1:0]   r_pe_fltr;
    logic [2*DATA_WIDTH-1:0] r_pe_psum;
    logic                    r_res_valid;
    logic [2*DATA_WIDTH-1:0] r_res_data;
    logic                    r_err;

    // ID register; a new ID applies to beats from the cycle after the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_id <= '0;
        else if (id_wr) r_id <= id_in;
    end

    // Tag match, ready and push per channel; unmatched or masked beats are consumed and dropped.
    always_comb begin
        w_match   = '0;
        bus_ready = '1;
        w_push    = '0;
        for (int k = 0; k < 3; k++) begin
            w_match[k] = (bus_tag[k*IDW +: IDW] == r_id);
`ifdef TMC_BROADCAST_EN
            w_match[k] = w_match[k] | bus_bcast[k];
`endif
            bus_ready[k] = !w_match[k] | !cfg_ch_mask[k] | !w_full[k];
            w_push[k]    = bus_valid[k] & bus_ready[k] & w_match[k] & cfg_ch_mask[k];
        end
    end

    // Fire when idle, the PE is ready, and every enabled channel has a beat; an empty mask never fires.
    always_comb begin
        w_fire = (r_state == S_IDLE) & pe_ready & (|cfg_ch_mask) & (&(~cfg_ch_mask | ~w_empty));
        w_pop  = {3{w_fire}} & cfg_ch_mask;
    end

    tmc_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_ifmap (
        .clk(clk), .rst_n(rst_n), .i_push(w_push[0]), .i_din(bus_ifmap), .i_pop(w_pop[0]),
        .o_dout(w_head_ifmap), .o_full(w_full[0]), .o_empty(w_empty[0])
    );
    tmc_fifo #(.W(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_fltr (
        .clk(clk), .rst_n(rst_n), .i_push(w_push[1]), .i_din(bus_fltr), .i_pop(w_pop[1]),
        .o_dout(w_head_fltr), .o_full(w_full[1]), .o_empty(w_empty[1])
    );
    tmc_fifo #(.W(2*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_psum (
        .clk(clk), .rst_n(rst_n), .i_push(w_push[2]), .i_din(bus_psum), .i_pop(w_pop[2]),
        .o_dout(w_head_psum), .o_full(w_full[2]), .o_empty(w_empty[2])
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // FSM next state: fire, then wait for the PE result, then wait for the bus to take it.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fire)                   w_state_next = S_BUSY;
            S_BUSY:  if (pe_valid)                 w_state_next = S_DRAIN;
            S_DRAIN: if (r_res_valid && res_ready) w_state_next = S_IDLE;
            default:                               w_state_next = S_IDLE;
        endcase
    end

    // Registered PE operands and fire pulse; masked-out operands are zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pe_en    <= 1'b0;
            r_pe_ifmap <= '0;
            r_pe_fltr  <= '0;
            r_pe_psum  <= '0;
        end else begin
            r_pe_en <= w_fire;
            if (w_fire) begin
                r_pe_ifmap <= cfg_ch_mask[0] ? w_head_ifmap : '0;
                r_pe_fltr  <= cfg_ch_mask[1] ? w_head_fltr  : '0;
                r_pe_psum  <= cfg_ch_mask[2] ? w_head_psum  : '0;
            end
        end
    end

    // Result return path; a stray pe_valid outside BUSY sets the sticky error flag and is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_err       <= 1'b0;
        end else begin
            if (r_state == S_BUSY && pe_valid) begin
                r_res_valid <= 1'b1;
                r_res_data  <= pe_res;
            end else if (r_state == S_DRAIN && r_res_valid && res_ready) begin
                r_res_valid <= 1'b0;
            end
            if (pe_valid && r_state != S_BUSY) r_err <= 1'b1;
        end
    end

    assign pe_en     = r_pe_en;
    assign pe_ifmap  = r_pe_ifmap;
    assign pe_fltr   = r_pe_fltr;
    assign pe_psum   = r_pe_psum;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign err       = r_err;
endmodule

`default_nettype wire

// File: tb/tb_tagged_multicaster.sv
// Testbench for tagged_multicaster: directed scenarios plus a randomized run checked
// against a queue-based reference model of the endpoint.
`timescale 1ns/1ps

module tb_tagged_multicaster;
    localparam int DW    = 16;
    localparam int NCOL  = 4;
    localparam int DEPTH = 2;
    localparam int IDW   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            id_wr;
    logic [IDW-1:0]  id_in;
    logic [2:0]      cfg_ch_mask;
    logic [2:0]      bus_valid;
    logic [2:0]      bus_ready;
    logic [3*IDW-1:0] bus_tag;
    logic [2:0]      bus_bcast;
    logic [DW-1:0]   bus_ifmap, bus_fltr;
    logic [2*DW-1:0] bus_psum;
    logic            pe_ready, pe_en, pe_valid, res_valid, res_ready, err;
    logic [DW-1:0]   pe_ifmap, pe_fltr;
    logic [2*DW-1:0] pe_psum, pe_res, res_data;

    int n_tests = 0;
    int n_fail  = 0;

    tagged_multicaster #(.DATA_WIDTH(DW), .NUM_COL(NCOL), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .id_wr(id_wr), .id_in(id_in), .cfg_ch_mask(cfg_ch_mask),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_tag(bus_tag),
`ifdef TMC_BROADCAST_EN
        .bus_bcast(bus_bcast),
`endif
        .bus_ifmap(bus_ifmap), .bus_fltr(bus_fltr), .bus_psum(bus_psum),
        .pe_ready(pe_ready), .pe_en(pe_en), .pe_ifmap(pe_ifmap), .pe_fltr(pe_fltr),
        .pe_psum(pe_psum), .pe_valid(pe_valid), .pe_res(pe_res), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .err(err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // One queue per channel, the ID, and a three-phase view of the PE job:
    // 0 = free to fire, 1 = waiting for the PE result, 2 = result offered to the bus.
    logic [DW-1:0]   m_if_q[$];
    logic [DW-1:0]   m_fl_q[$];
    logic [2*DW-1:0] m_ps_q[$];
    logic [IDW-1:0]  m_id;
    int              m_phase;
    logic            m_pe_en;
    logic [DW-1:0]   m_op_if, m_op_fl;
    logic [2*DW-1:0] m_op_ps;
    logic            m_res_valid;
    logic [2*DW-1:0] m_res_data;
    logic            m_err;
    logic [2:0]      m_rdy;
    logic            m_fire;

    function automatic logic model_match(int k);
        logic m;
        m = (bus_tag[k*IDW +: IDW] == m_id);
`ifdef TMC_BROADCAST_EN
        m = m | bus_bcast[k];
`endif
        return m;
    endfunction

    function automatic int model_size(int k);
        if (k == 0) return m_if_q.size();
        if (k == 1) return m_fl_q.size();
        return m_ps_q.size();
    endfunction

    function automatic logic [2:0] model_ready();
        logic [2:0] r;
        for (int k = 0; k < 3; k++)
            r[k] = !model_match(k) || !cfg_ch_mask[k] || (model_size(k) < DEPTH);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_if_q.delete(); m_fl_q.delete(); m_ps_q.delete();
            m_id = '0; m_phase = 0; m_pe_en = 1'b0;
            m_op_if = '0; m_op_fl = '0; m_op_ps = '0;
            m_res_valid = 1'b0; m_res_data = '0; m_err = 1'b0;
        end else begin
            m_rdy  = model_ready();
            m_fire = (m_phase == 0) && pe_ready && (cfg_ch_mask != 3'b000) &&
                     (!cfg_ch_mask[0] || m_if_q.size() > 0) &&
                     (!cfg_ch_mask[1] || m_fl_q.size() > 0) &&
                     (!cfg_ch_mask[2] || m_ps_q.size() > 0);
            if (pe_valid && m_phase != 1) m_err = 1'b1;
            if (m_phase == 1 && pe_valid) begin
                m_res_valid = 1'b1; m_res_data = pe_res; m_phase = 2;
            end else if (m_phase == 2 && res_ready) begin
                m_res_valid = 1'b0; m_phase = 0;
            end else if (m_fire) begin
                m_phase = 1;
            end
            m_pe_en = m_fire;
            if (m_fire) begin
                m_op_if = cfg_ch_mask[0] ? m_if_q.pop_front() : '0;
                m_op_fl = cfg_ch_mask[1] ? m_fl_q.pop_front() : '0;
                m_op_ps = cfg_ch_mask[2] ? m_ps_q.pop_front() : '0;
            end
            if (bus_valid[0] && m_rdy[0] && model_match(0) && cfg_ch_mask[0]) m_if_q.push_back(bus_ifmap);
            if (bus_valid[1] && m_rdy[1] && model_match(1) && cfg_ch_mask[1]) m_fl_q.push_back(bus_fltr);
            if (bus_valid[2] && m_rdy[2] && model_match(2) && cfg_ch_mask[2]) m_ps_q.push_back(bus_psum);
            if (id_wr) m_id = id_in;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_wr = 0; id_in = 0; cfg_ch_mask = 0; bus_valid = 0; bus_tag = 0; bus_bcast = 0;
        bus_ifmap = 0; bus_fltr = 0; bus_psum = 0; pe_ready = 0; pe_valid = 0; pe_res = 0;
        res_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
    endtask

    task automatic set_id(input logic [IDW-1:0] v);
        id_wr = 1; id_in = v;
        tick();
        id_wr = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        tick(); tick();
        n_tests++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL reset_pe_en: got %0h want 0", pe_en); end
        n_tests++; if ({pe_ifmap, pe_fltr, pe_psum} !== '0) begin n_fail++; $display("FAIL reset_operands: got %0h %0h %0h want 0", pe_ifmap, pe_fltr, pe_psum); end
        n_tests++; if (res_valid !== 1'b0 || res_data !== '0) begin n_fail++; $display("FAIL reset_res: got v=%0h d=%0h want 0", res_valid, res_data); end
        n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0h want 0", err); end
        n_tests++; if (bus_ready !== 3'b111) begin n_fail++; $display("FAIL reset_bus_ready: got %b want 111", bus_ready); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_basic_fire();
        do_reset();
        set_id(2);
        cfg_ch_mask = 3'b111; pe_ready = 1;
        bus_tag = {2'd2, 2'd2, 2'd2};
        bus_valid = 3'b111; bus_ifmap = 16'h0011; bus_fltr = 16'h0003; bus_psum = 32'h5;
        tick();
        bus_valid = 0;
        n_tests++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL basic_early_pe_en: got %0h want 0", pe_en); end
        tick();
        n_tests++; if (pe_en !== 1'b1) begin n_fail++; $display("FAIL basic_pe_en: got %0h want 1", pe_en); end
        n_tests++; if ({pe_ifmap, pe_fltr, pe_psum} !== {16'h0011, 16'h0003, 32'h5}) begin
            n_fail++; $display("FAIL basic_operands: got %0h %0h %0h want 11 3 5", pe_ifmap, pe_fltr, pe_psum); end
        tick();
        n_tests++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %0h want 0", pe_en); end
        pe_valid = 1; pe_res = 32'h38;
        tick();
        pe_valid = 0;
        n_tests++; if (res_valid !== 1'b1 || res_data !== 32'h38) begin
            n_fail++; $display("FAIL basic_result: got v=%0h d=%0h want 1 38", res_valid, res_data); end
        res_ready = 1;
        tick();
        res_ready = 0;
        n_tests++; if (res_valid !== 1'b0 || res_data !== 32'h38) begin
            n_fail++; $display("FAIL basic_result_accept: got v=%0h d=%0h want 0 38", res_valid, res_data); end
    endtask

    task automatic test_tag_filter();
        do_reset();
        set_id(2);
        cfg_ch_mask = 3'b111; pe_ready = 1;
        bus_tag = {2'd2, 2'd2, 2'd1};
        for (int i = 0; i < 4; i++) begin
            bus_valid = 3'b001; bus_ifmap = 16'($urandom);
            #1;
            n_tests++; if (bus_ready[0] !== 1'b1) begin n_fail++; $display("FAIL tag_ready[%0d]: got %0h want 1", i, bus_ready[0]); end
            tick();
        end
        bus_valid = 3'b110; bus_fltr = 16'h7; bus_psum = 32'h9;
        tick();
        bus_valid = 0;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL tag_no_fire[%0d]: got %0h want 0", i, pe_en); end
            tick();
        end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        set_id(2);
        cfg_ch_mask = 3'b001; pe_ready = 0;
        bus_tag = {2'd2, 2'd2, 2'd2};
        bus_valid = 3'b001; bus_ifmap = 16'hA001; #1;
        n_tests++; if (bus_ready[0] !== 1'b1) begin n_fail++; $display("FAIL full_ready_b1: got %0h want 1", bus_ready[0]); end
        tick();
        bus_ifmap = 16'hA002; #1;
        n_tests++; if (bus_ready[0] !== 1'b1) begin n_fail++; $display("FAIL full_ready_b2: got %0h want 1", bus_ready[0]); end
        tick();
        bus_ifmap = 16'hA003; #1;
        n_tests++; if (bus_ready[0] !== 1'b0) begin n_fail++; $display("FAIL full_ready_b3: got %0h want 0", bus_ready[0]); end
        tick();
        n_tests++; if (bus_ready[0] !== 1'b0 || pe_en !== 1'b0) begin
            n_fail++; $display("FAIL full_held: got rdy=%0h en=%0h want 0 0", bus_ready[0], pe_en); end
        pe_ready = 1; #1;
        n_tests++; if (bus_ready[0] !== 1'b0) begin n_fail++; $display("FAIL full_no_pop_bypass: got %0h want 0", bus_ready[0]); end
        tick();
        n_tests++; if (pe_en !== 1'b1 || pe_ifmap !== 16'hA001 || pe_fltr !== '0 || pe_psum !== '0) begin
            n_fail++; $display("FAIL full_fire1: got en=%0h %0h %0h %0h want 1 a001 0 0", pe_en, pe_ifmap, pe_fltr, pe_psum); end
        n_tests++; if (bus_ready[0] !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %0h want 1", bus_ready[0]); end
        tick();
        bus_valid = 0;
        for (int j = 0; j < 2; j++) begin
            pe_valid = 1; pe_res = 32'(j);
            tick();
            pe_valid = 0; res_ready = 1;
            tick();
            res_ready = 0;
            n_tests++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL full_gap[%0d]: got %0h want 0", j, pe_en); end
            tick();
            n_tests++; if (pe_en !== 1'b1 || pe_ifmap !== (j == 0 ? 16'hA002 : 16'hA003)) begin
                n_fail++; $display("FAIL full_fire%0d: got en=%0h ifmap=%0h want 1 %0h", j + 2, pe_en, pe_ifmap,
                                   (j == 0 ? 16'hA002 : 16'hA003)); end
        end
    endtask

    task automatic test_drain_hold();
        do_reset();
        set_id(2);
        cfg_ch_mask = 3'b111; pe_ready = 1;
        bus_tag = {2'd2, 2'd2, 2'd2};
        bus_valid = 3'b111; bus_ifmap = 16'h11; bus_fltr = 16'h3; bus_psum = 32'h5;
        tick();
        bus_valid = 0;
        tick();
        n_tests++; if (pe_en !== 1'b1) begin n_fail++; $display("FAIL drain_fire: got %0h want 1", pe_en); end
        pe_valid = 1; pe_res = 32'hBEEF;
        tick();
        pe_valid = 0;
        bus_valid = 3'b111; bus_ifmap = 16'h22; bus_fltr = 16'h4; bus_psum = 32'h6;
        tick();
        bus_valid = 0;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (pe_en !== 1'b0 || res_valid !== 1'b1 || res_data !== 32'hBEEF) begin
                n_fail++; $display("FAIL drain_hold[%0d]: got en=%0h v=%0h d=%0h want 0 1 beef", i, pe_en, res_valid, res_data); end
            tick();
        end
        pe_valid = 1; pe_res = 32'hDEAD;
        tick();
        pe_valid = 0;
        n_tests++; if (err !== 1'b1 || res_data !== 32'hBEEF) begin
            n_fail++; $display("FAIL drain_err: got err=%0h d=%0h want 1 beef", err, res_data); end
        tick(); tick(); tick();
        n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %0h want 1", err); end
    endtask

    task automatic test_reset_mid_busy();
        res_ready = 1;
        tick();
        res_ready = 0;
        tick();
        n_tests++; if (pe_en !== 1'b1 || pe_ifmap !== 16'h22) begin
            n_fail++; $display("FAIL busy_fire: got en=%0h ifmap=%0h want 1 22", pe_en, pe_ifmap); end
        #2;
        rst_n = 0;
        #1;
        n_tests++; if ({pe_en, res_valid, err} !== 3'b000 || {pe_ifmap, pe_fltr, pe_psum, res_data} !== '0) begin
            n_fail++; $display("FAIL async_reset: got en=%0h v=%0h err=%0h d=%0h want 0", pe_en, res_valid, err, res_data); end
        n_tests++; if (bus_ready !== 3'b111) begin n_fail++; $display("FAIL async_reset_ready: got %b want 111", bus_ready); end
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_broadcast();
        do_reset();
        set_id(2);
        cfg_ch_mask = 3'b001; pe_ready = 1;
        bus_tag = {2'd2, 2'd2, 2'd1}; bus_bcast = 3'b001;
        bus_valid = 3'b001; bus_ifmap = 16'h77;
        tick();
        bus_valid = 0; bus_bcast = 0;
        tick();
`ifdef TMC_BROADCAST_EN
        n_tests++; if (pe_en !== 1'b1 || pe_ifmap !== 16'h77) begin
            n_fail++; $display("FAIL bcast_pushed: got en=%0h ifmap=%0h want 1 77", pe_en, pe_ifmap); end
`else
        n_tests++; if (pe_en !== 1'b0) begin n_fail++; $display("FAIL bcast_dropped: got %0h want 0", pe_en); end
`endif
    endtask

    task automatic test_random();
        int errs;
        logic [2:0] exp_rdy;
        do_reset();
        errs = 0;
        cfg_ch_mask = 3'b111;
        for (int c = 0; c < 3000; c++) begin
            id_wr = ($urandom_range(0, 59) == 0);
            id_in = IDW'($urandom_range(0, NCOL - 1));
            if ($urandom_range(0, 99) == 0) cfg_ch_mask = ($urandom_range(0, 1) == 0) ? 3'b111 : 3'($urandom);
            bus_valid = 3'($urandom);
            for (int k = 0; k < 3; k++)
                bus_tag[k*IDW +: IDW] = ($urandom_range(0, 9) < 6) ? m_id : IDW'($urandom_range(0, NCOL - 1));
            bus_bcast = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            bus_ifmap = 16'($urandom); bus_fltr = 16'($urandom); bus_psum = $urandom;
            pe_ready  = ($urandom_range(0, 3) != 0);
            pe_valid  = (m_phase == 1) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 799) == 0);
            pe_res    = $urandom;
            res_ready = $urandom_range(0, 1);
            #1;
            exp_rdy = model_ready();
            n_tests++;
            if (bus_ready !== exp_rdy || pe_en !== m_pe_en || res_valid !== m_res_valid ||
                res_data !== m_res_data || err !== m_err ||
                (m_pe_en && {pe_ifmap, pe_fltr, pe_psum} !== {m_op_if, m_op_fl, m_op_ps})) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL random[%0d]: got rdy=%b en=%0h ops=%0h/%0h/%0h rv=%0h rd=%0h err=%0h want rdy=%b en=%0h ops=%0h/%0h/%0h rv=%0h rd=%0h err=%0h",
                             c, bus_ready, pe_en, pe_ifmap, pe_fltr, pe_psum, res_valid, res_data, err,
                             exp_rdy, m_pe_en, m_op_if, m_op_fl, m_op_ps, m_res_valid, m_res_data, m_err);
                errs++;
            end
            tick();
        end
        clear_inputs();
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        clear_inputs();
        rst_n = 0;
        test_reset();
        test_basic_fire();
        test_tag_filter();
        test_full_backpressure();
        test_drain_hold();
        test_reset_mid_busy();
        test_broadcast();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
